// File: rtl/sd_sector_uart_tx.sv
// Buffers SD sector read bytes in a circular buffer and streams them out as 8N1 UART frames,
// tracking sector count, buffer overflow and sector-length errors for host-side card dumps.
module sd_sector_uart_tx #(
    parameter int UART_BPS     = 921600,
    parameter int CLK_FREQ     = 20_000_000,
    parameter int BUF_DEPTH    = 1024,
    parameter int SECTOR_BYTES = 512
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_en,
    input  logic [7:0]                 in_byte,
    input  logic                       in_done,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(BUF_DEPTH):0] level,
    output logic                       overflow,
    output logic                       len_err,
    output logic [15:0]                sector_cnt
);
    localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
    localparam int AW       = $clog2(BUF_DEPTH);
    localparam int BW       = $clog2(BAUD_DIV + 1);
    localparam logic [AW:0]    FULL      = (AW + 1)'(BUF_DEPTH);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [10:0]    SEC_LEN   = 11'(SECTOR_BYTES);

    if (BAUD_DIV < 2) begin : g_baud_chk
        $error("BAUD_DIV = CLK_FREQ/UART_BPS must be at least 2");
    end
    if (BUF_DEPTH < 16 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("BUF_DEPTH must be a power of 2 and at least 16");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          pop;

    logic [7:0]    mem [BUF_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   level_q;
    logic          overflow_q, len_err_q;
    logic [15:0]   sector_q;
    logic [9:0]    sec_bytes_q;
    logic [10:0]   sec_len;
    logic          push;

    // Full is judged on the pre-cycle level, so a same-cycle pop never rescues a byte.
    assign push    = in_en && (level_q != FULL);
    assign sec_len = {1'b0, sec_bytes_q} + {10'd0, in_en};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            len_err_q   <= 1'b0;
            sector_q    <= '0;
            sec_bytes_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            if (in_en && !push) overflow_q <= 1'b1;
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (in_done) begin
                sector_q    <= sector_q + 16'd1;
                sec_bytes_q <= '0;
                if (sec_len != SEC_LEN) len_err_q <= 1'b1;
            end else if (in_en) begin
                sec_bytes_q <= sec_bytes_q + 10'd1;
            end
        end
    end

    // NOTE: the byte store is not reset; the pointers and level alone define valid contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= in_byte;
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || (level_q != '0);
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign len_err    = len_err_q;
    assign sector_cnt = sector_q;
endmodule

// File: tb/tb_sd_sector_uart_tx.sv
// Directed bench for sd_sector_uart_tx: BAUD_DIV=4, 16-byte buffer, a negedge UART receiver
// collecting frames into a queue, and one task per scenario with inline comparisons.
module tb_sd_sector_uart_tx;
    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_en = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_done = 1'b0;
    logic        tx, busy, overflow, len_err;
    logic [4:0]  level;
    logic [15:0] sector_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_q[$];
    bit         rx_active = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh;

    sd_sector_uart_tx #(
        .UART_BPS(4), .CLK_FREQ(16), .BUF_DEPTH(16), .SECTOR_BYTES(512)
    ) dut (
        .clk(clk), .rstn(rstn), .in_en(in_en), .in_byte(in_byte), .in_done(in_done),
        .tx(tx), .busy(busy), .level(level), .overflow(overflow), .len_err(len_err),
        .sector_cnt(sector_cnt)
    );

    always #5 clk = ~clk;

    // Receiver: start detected at count 0, bits sampled mid-bit at counts 2, 6, ... 38.
    always @(negedge clk) begin
        if (!rstn) begin
            rx_active = 0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % BD == BD / 2) begin
                if (rx_cnt / BD >= 1 && rx_cnt / BD <= 8) rx_sh[rx_cnt / BD - 1] = tx;
                if (rx_cnt / BD == 9) begin
                    n_checks++;
                    if (tx !== 1'b1) $display("FAIL stop_bit: tx=%b required 1", tx);
                    else n_pass++;
                    rx_q.push_back(rx_sh);
                    rx_active = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        in_en = 1'b0;
        in_done = 1'b0;
        rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(1);
        rx_q.delete();
    endtask

    task automatic push(input logic [7:0] b);
        in_en = 1'b1;
        in_byte = b;
        tick(1);
        in_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({tx, busy, level, overflow, len_err, sector_cnt} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 16'd0})
            $display("FAIL reset_state: tx=%b busy=%b level=%0d ovf=%b len_err=%b sectors=%0d required 1 0 0 0 0 0",
                     tx, busy, level, overflow, len_err, sector_cnt);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [9:0] fr;
        int         bad;
        fr = {1'b1, 8'hA5, 1'b0};
        do_reset();
        push(8'hA5);
        n_checks++;
        if (level !== 5'd1 || tx !== 1'b1) $display("FAIL single_push: level=%0d tx=%b required 1 1", level, tx);
        else n_pass++;
        tick(1);
        n_checks++;
        if (level !== 5'd0 || busy !== 1'b1 || tx !== 1'b1)
            $display("FAIL single_pop: level=%0d busy=%b tx=%b required 0 1 1", level, busy, tx);
        else n_pass++;
        bad = -1;
        for (int k = 0; k < 10 * BD; k++) begin
            tick(1);
            if (tx !== fr[k / BD] && bad < 0) bad = k;
        end
        n_checks++;
        if (bad >= 0) $display("FAIL single_waveform: first wrong cycle %0d, tx=%b required %b", bad, ~fr[bad / BD], fr[bad / BD]);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL single_idle: busy=%b tx=%b required 0 1", busy, tx);
        else n_pass++;
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) $display("FAIL single_rx: got %0d bytes first=%h required 1 byte a5", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] lv[3];
        do_reset();
        push(8'h01); lv[0] = level;
        push(8'h02); lv[1] = level;
        push(8'h03); lv[2] = level;
        n_checks++;
        if (lv[0] !== 5'd1 || lv[1] !== 5'd1 || lv[2] !== 5'd2)
            $display("FAIL b2b_level: %0d %0d %0d required 1 1 2", lv[0], lv[1], lv[2]);
        else n_pass++;
        n_checks++;
        if (tx !== 1'b0) $display("FAIL b2b_start0: tx=%b required 0", tx);
        else n_pass++;
        for (int f = 1; f < 3; f++) begin
            tick(10 * BD - 1);
            n_checks++;
            if (tx !== 1'b1) $display("FAIL b2b_stop%0d: tx=%b required 1", f - 1, tx);
            else n_pass++;
            tick(1);
            n_checks++;
            if (tx !== 1'b0) $display("FAIL b2b_start%0d: tx=%b required 0 (no idle gap)", f, tx);
            else n_pass++;
        end
        tick(10 * BD + 5);
        n_checks++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'h01 || rx_q[1] !== 8'h02 || rx_q[2] !== 8'h03 || busy !== 1'b0)
            $display("FAIL b2b_rx: got %0d bytes busy=%b required 01 02 03 and idle", rx_q.size(), busy);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int bad;
        do_reset();
        for (int i = 0; i < 20; i++) push(8'h10 + 8'(i));
        n_checks++;
        if (level !== 5'd16 || overflow !== 1'b1)
            $display("FAIL ovf_burst: level=%0d overflow=%b required 16 1", level, overflow);
        else n_pass++;
        tick(17 * 10 * BD + 10);
        bad = (rx_q.size() != 17) ? 99 : -1;
        for (int i = 0; i < 17 && bad < 0; i++) if (rx_q[i] !== 8'h10 + 8'(i)) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL ovf_rx: %0d bytes, first bad index %0d, required 17 bytes 10..20", rx_q.size(), bad);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || level !== 5'd0) $display("FAIL ovf_drain: busy=%b level=%0d required 0 0", busy, level);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int bad;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            push(8'(i));
            tick(10 * BD - 1);
        end
        tick(10 * BD + 5);
        bad = (rx_q.size() != 40) ? 99 : -1;
        for (int i = 0; i < 40 && bad < 0; i++) if (rx_q[i] !== 8'(i)) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL wrap_rx: %0d bytes, first bad index %0d, required 40 bytes 00..27", rx_q.size(), bad);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL wrap_ovf: overflow=%b required 0", overflow);
        else n_pass++;
    endtask

    task automatic test_sector();
        do_reset();
        for (int i = 0; i < 512; i++) push(8'(i));
        in_done = 1'b1; tick(1); in_done = 1'b0;
        n_checks++;
        if (sector_cnt !== 16'd1 || len_err !== 1'b0)
            $display("FAIL sector_512: sectors=%0d len_err=%b required 1 0", sector_cnt, len_err);
        else n_pass++;
        for (int i = 0; i < 510; i++) push(8'(i));
        in_done = 1'b1; push(8'hEE); in_done = 1'b0;
        n_checks++;
        if (sector_cnt !== 16'd2 || len_err !== 1'b1)
            $display("FAIL sector_511: sectors=%0d len_err=%b required 2 1", sector_cnt, len_err);
        else n_pass++;
        for (int i = 0; i < 511; i++) push(8'(i));
        in_done = 1'b1; push(8'hEF); in_done = 1'b0;
        n_checks++;
        if (sector_cnt !== 16'd3 || len_err !== 1'b1)
            $display("FAIL sector_sticky: sectors=%0d len_err=%b required 3 1", sector_cnt, len_err);
        else n_pass++;
        do_reset();
        for (int i = 0; i < 511; i++) push(8'(i));
        in_done = 1'b1; push(8'hF0); in_done = 1'b0;
        n_checks++;
        if (sector_cnt !== 16'd1 || len_err !== 1'b0)
            $display("FAIL sector_coincident: sectors=%0d len_err=%b required 1 0", sector_cnt, len_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit tx_low;
        do_reset();
        for (int i = 0; i < 20; i++) push(8'h40 + 8'(i));
        in_done = 1'b1; tick(1); in_done = 1'b0;
        tick(8);
        n_checks++;
        if (overflow !== 1'b1 || sector_cnt !== 16'd1 || level !== 5'd16)
            $display("FAIL mid_pre: overflow=%b sectors=%0d level=%0d required 1 1 16", overflow, sector_cnt, level);
        else n_pass++;
        rstn = 1'b0;
        tick(1);
        n_checks++;
        if ({tx, busy, level, overflow, sector_cnt} !== {1'b1, 1'b0, 5'd0, 1'b0, 16'd0})
            $display("FAIL mid_reset: tx=%b busy=%b level=%0d ovf=%b sectors=%0d required 1 0 0 0 0",
                     tx, busy, level, overflow, sector_cnt);
        else n_pass++;
        tick(1);
        rstn = 1'b1;
        rx_q.delete();
        tx_low = 0;
        for (int k = 0; k < 20 * BD; k++) begin
            tick(1);
            if (tx !== 1'b1) tx_low = 1;
        end
        n_checks++;
        if (tx_low || rx_q.size() != 0 || busy !== 1'b0)
            $display("FAIL mid_quiet: tx_low=%b frames=%0d busy=%b required 0 0 0", tx_low, rx_q.size(), busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_sector();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
